// File: rtl/sync_fifo_pkg.sv
// Shared types, defaults and helpers for the sync_fifo_buf slice.
package sync_fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_DEPTH      = 8;

    // Pointer carries one extra wrap bit above the memory index.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_buf_if.sv
// Producer/consumer port bundle for sync_fifo_buf; slave is the FIFO side.
interface sync_fifo_buf_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
);
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  err_clr;

    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_ptr.sv
// Pointer, occupancy and status-flag controller for sync_fifo_buf.
module sync_fifo_ptr
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned AFULL_LVL  = DEPTH - 1,
    parameter int unsigned AEMPTY_LVL = 1,
    localparam int unsigned PW        = ptr_width(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic          wr_accept,
    output logic          rd_accept,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [PW-1:0] count,
    output fifo_status_t  status
);

    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_LVL);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_LVL);
    localparam logic [PW-1:0] ONE_C    = PW'(1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q,  count_d;
    logic          full_w, empty_w;

    always_comb begin
        full_w  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                  (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
        empty_w = (wr_ptr_q == rd_ptr_q);
    end

    always_comb begin
        wr_accept = wr_en & ~full_w;
        rd_accept = rd_en & ~empty_w;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (wr_accept) wr_ptr_d = wr_ptr_q + ONE_C;
        if (rd_accept) rd_ptr_d = rd_ptr_q + ONE_C;
        if (wr_accept && !rd_accept) count_d = count_q + ONE_C;
        else if (rd_accept && !wr_accept) count_d = count_q - ONE_C;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        wr_ptr              = wr_ptr_q;
        rd_ptr              = rd_ptr_q;
        count               = count_q;
        status.full         = full_w;
        status.empty        = empty_w;
        status.almost_full  = (count_q >= AFULL_C);
        status.almost_empty = (count_q <= AEMPTY_C);
    end

endmodule

// File: rtl/sync_fifo_buf.sv
// Single-clock flop-based FIFO with registered read port and status flags.
// Sticky overflow/underflow flags are built only with SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_buf
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned AFULL_LVL  = DEPTH - 1,
    parameter int unsigned AEMPTY_LVL = 1
) (
    input logic           CLK,
    input logic           RST,
    sync_fifo_buf_if.slave bus
);

    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam int unsigned PW         = ptr_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    logic                  wr_accept, rd_accept;
    logic [PW-1:0]         wr_ptr, rd_ptr, count;
    fifo_status_t          status;

    sync_fifo_ptr #(
        .DEPTH      (DEPTH),
        .AFULL_LVL  (AFULL_LVL),
        .AEMPTY_LVL (AEMPTY_LVL)
    ) u_ptr (
        .CLK       (CLK),
        .RST       (RST),
        .wr_en     (bus.wr_en),
        .rd_en     (bus.rd_en),
        .wr_accept (wr_accept),
        .rd_accept (rd_accept),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count),
        .status    (status)
    );

    always_comb begin
        mem_d      = mem_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_accept;
        if (wr_accept) mem_d[wr_ptr[ADDR_WIDTH-1:0]] = bus.wr_data;
        // Read samples pre-edge memory, so a same-cycle write is never bypassed.
        if (rd_accept) rd_data_d = mem_q[rd_ptr[ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Clear first so a new error in the same cycle wins.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (bus.wr_en && status.full)  overflow_d  = 1'b1;
        if (bus.rd_en && status.empty) underflow_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        bus.overflow  = overflow_q;
        bus.underflow = underflow_q;
    end
`else
    logic unused_err_clr;

    always_comb begin
        unused_err_clr = bus.err_clr;
        bus.overflow   = 1'b0;
        bus.underflow  = 1'b0;
    end
`endif

    always_comb begin
        bus.rd_data      = rd_data_q;
        bus.rd_valid     = rd_valid_q;
        bus.count        = count;
        bus.full         = status.full;
        bus.empty        = status.empty;
        bus.almost_full  = status.almost_full;
        bus.almost_empty = status.almost_empty;
    end

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Self-checking bench for sync_fifo_buf: directed scenarios plus random traffic vs a queue model.
module tb_sync_fifo_buf;

    localparam int unsigned DW     = 8;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned AF_LVL = DEPTH - 1;
    localparam int unsigned AE_LVL = 1;

    logic clk;
    logic rst;

    sync_fifo_buf_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    sync_fifo_buf #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AFULL_LVL  (AF_LVL),
        .AEMPTY_LVL (AE_LVL)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Reference model: a plain queue of stored words plus last popped word.
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_rd_data;
    logic          exp_rd_valid;
    logic          exp_ovf;
    logic          exp_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        exp_rd_data  = '0;
        exp_rd_valid = 1'b0;
        exp_ovf      = 1'b0;
        exp_unf      = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int unsigned n;
        n = q.size();
        check({tag, ".count"},    32'(bus.count),        32'(n));
        check({tag, ".full"},     32'(bus.full),         32'(n == DEPTH));
        check({tag, ".empty"},    32'(bus.empty),        32'(n == 0));
        check({tag, ".afull"},    32'(bus.almost_full),  32'(n >= AF_LVL));
        check({tag, ".aempty"},   32'(bus.almost_empty), 32'(n <= AE_LVL));
        check({tag, ".rd_valid"}, 32'(bus.rd_valid),     32'(exp_rd_valid));
        check({tag, ".rd_data"},  32'(bus.rd_data),      32'(exp_rd_data));
        check({tag, ".overflow"}, 32'(bus.overflow),     32'(exp_ovf));
        check({tag, ".underflow"},32'(bus.underflow),    32'(exp_unf));
    endtask

    // One clock with the given inputs; model advances from the pre-edge occupancy.
    task automatic step(input string tag, input logic w, input logic [DW-1:0] d,
                        input logic r, input logic c);
        bit was_full, was_empty;
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = r;
        bus.err_clr = c;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        @(posedge clk);
        #1;
        exp_rd_valid = r && !was_empty;
        if (r && !was_empty) exp_rd_data = q.pop_front();
        if (w && !was_full) q.push_back(d);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        if (c) begin
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end
        if (w && was_full)  exp_ovf = 1'b1;
        if (r && was_empty) exp_unf = 1'b1;
`endif
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
        check_all(tag);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #2 rst = 1'b0;

        // Fill 0x01..0x08, then a dropped 9th write.
        for (int i = 1; i <= int'(DEPTH); i++) step("fill", 1'b1, DW'(i), 1'b0, 1'b0);
        step("fill_drop", 1'b1, 8'hFF, 1'b0, 1'b0);
        step("ovf_hold", 1'b0, 8'h00, 1'b0, 1'b0);

        // Drain, then a read on empty.
        for (int i = 0; i < int'(DEPTH); i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        step("drain_empty", 1'b0, 8'h00, 1'b1, 1'b0);
        step("err_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        step("err_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Wrap-around: 5 in/out, then 8 in/out.
        for (int i = 0; i < 5; i++) step("wrap_w5", 1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("wrap_r5", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step("wrap_w8", 1'b1, DW'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step("wrap_r8", 1'b0, 8'h00, 1'b1, 1'b0);

        // Concurrent read/write at count 0, 4 and 8.
        step("rw_empty", 1'b1, 8'h30, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) step("to4", 1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("rw_mid", 1'b1, DW'(8'h40 + i), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step("to8", 1'b1, DW'(8'h50 + i), 1'b0, 1'b0);
        step("rw_full", 1'b1, 8'h60, 1'b1, 1'b0);
        step("refill", 1'b1, 8'h61, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("down5", 1'b0, 8'h00, 1'b1, 1'b0);
        check("count_is5", 32'(bus.count), 32'd5);

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("async.empty",   32'(bus.empty),   32'd1);
        check("async.count",   32'(bus.count),   32'd0);
        check("async.rd_data", 32'(bus.rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step("post_rst_w", 1'b1, 8'hA5, 1'b0, 1'b0);
        step("post_rst_r", 1'b0, 8'h00, 1'b1, 1'b0);
        check("post_rst_data", 32'(bus.rd_data), 32'hA5);

        // Random traffic with occasional error clears.
        for (int i = 0; i < 600; i++) begin
            logic w, r, c;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            c = ($urandom_range(0, 99) < 5);
            step("rand", w, DW'($urandom), r, c);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sync_fifo_buf.md
Name: sync_fifo_buf

Overview:
Single-clock, parametrised FIFO buffer for same-domain producer/consumer paths, such as the register file to UART TX path. Flop-based storage with a registered read port. Provides full/empty, programmable almost-full/almost-empty, an occupancy count and optional sticky error flags. Generalises the dual-port FIFO memory to a self-contained buffer that owns its own pointers and status.

Parameters:
DATA_WIDTH, 8, width of each entry in bits
DEPTH, 8, number of entries; must be a power of two and at least 2
ADDR_WIDTH, $clog2(DEPTH), pointer index width (derived, not overridden)
AFULL_LVL, DEPTH-1, almost_full asserts when count >= AFULL_LVL
AEMPTY_LVL, 1, almost_empty asserts when count <= AEMPTY_LVL

Ports:
CLK  in  1  single clock; all state updates on its rising edge
RST  in  1  asynchronous, active-high reset
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
rd_en  in  1  read request
rd_data  out  DATA_WIDTH  registered read data
rd_valid  out  1  rd_data holds a newly popped word this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_LVL
almost_empty  out  1  count <= AEMPTY_LVL
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full (feature only)
underflow  out  1  sticky: read attempted while empty (feature only)
err_clr  in  1  synchronous clear of the sticky error flags (feature only)

Behaviour:
- Reset (RST=1, asynchronous): all memory entries, wr_ptr, rd_ptr, count, rd_data and rd_valid go to 0; overflow=0 and underflow=0. Resulting flags: empty=1, full=0, almost_empty=1, almost_full = (AFULL_LVL==0).
- Reset asserted mid-operation discards all contents immediately. First legal write is on the first rising edge after RST deasserts.
- Pointers are ADDR_WIDTH+1 bits: the MSB is the wrap bit and the low bits index memory.
  - full when the pointers differ only in the MSB.
  - empty when the pointers are equal.
  - Pointers wrap modulo 2*DEPTH, with no special-case logic.
- Write accepted = wr_en & ~full. On acceptance: mem[wr_ptr] <= wr_data and wr_ptr increments. A write while full is dropped, with no state change.
- Read accepted = rd_en & ~empty. On acceptance: rd_data <= mem[rd_ptr], rd_ptr increments, and rd_valid=1 on the following cycle.
  - Read latency is 1 cycle: rd_data and rd_valid are valid the cycle after rd_en.
  - rd_valid is a 1-cycle pulse per accepted read.
  - rd_data holds its last value when no read is accepted.
- A read while empty is ignored: rd_valid=0 and rd_data is unchanged.
- Simultaneous accepted write and read: both pointers advance and count is unchanged.
- Write while full is blocked even if rd_en is asserted the same cycle (no pass-through). Read while empty is blocked even with a concurrent write (no bypass). The written word becomes readable from the next cycle.
- count: +1 on write-only, -1 on read-only, unchanged otherwise. Never exceeds DEPTH and never goes below 0.
- full, empty, almost_full and almost_empty are combinational from registered count/pointers and reflect the state after the last edge.

Optional Feature:
SYNC_FIFO_ERR_FLAGS_EN
- Defined:
  - overflow sets on any cycle with wr_en & full.
  - underflow sets on any cycle with rd_en & empty.
  - Both remain set until err_clr=1 or RST.
  - If err_clr and a new error occur in the same cycle, set wins.
- Undefined: overflow and underflow are tied to 0 and err_clr is ignored. Ports remain present so the interface is identical.

Decomposition:
- Package sync_fifo_pkg holds:
  - a function computing the pointer width from DEPTH;
  - localparam defaults for DATA_WIDTH and DEPTH;
  - a status struct typedef {full, empty, almost_full, almost_empty}.
- One sub-module is natural: sync_fifo_ptr, a pointer/count/flag controller, instantiated once. It takes wr_en, rd_en and the parameters, and outputs the pointers, count and flags.
- Storage and the read register stay in the top level.

Test Plan:
1. Reset, then fill: DEPTH=8, write 0x01..0x08 on consecutive cycles.
   - count=8, full=1, almost_full=1 from count 7.
   - A 9th write of 0xFF is dropped; count stays 8.
2. Drain after fill: rd_en for 8 cycles.
   - rd_data = 0x01..0x08, each with rd_valid one cycle after its rd_en.
   - empty=1 after the 8th read; a 9th read gives rd_valid=0 and rd_data stays 0x08.
3. Wrap-around: 5 writes, 5 reads, then 8 writes, 8 reads. Data order is preserved across the pointer wrap; full and empty are correct at every step.
4. Simultaneous read and write at count=4: count stays 4 and data order is preserved.
   - At count=8 with wr_en+rd_en: only the read succeeds, count becomes 7.
   - At count=0 with wr_en+rd_en: only the write succeeds, count becomes 1 and rd_valid=0.
5. Asynchronous reset mid-stream: assert RST between clock edges with count=5.
   - Immediately empty=1, count=0 and rd_data=0, without waiting for an edge.
   - After release, write 0xA5 then read, giving 0xA5.
6. With SYNC_FIFO_ERR_FLAGS_EN: write while full sets overflow=1, which persists; read while empty sets underflow=1. err_clr=1 clears both next cycle. Without the macro, both stay 0 under the same stimulus.
